// File: rtl/mem_pkg.sv
// mem_pkg: shared types for the backing-store responder.
// FSM state enum, default widths and the write-back entry struct.
package mem_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_buffer.sv
// wb_buffer: 2-entry write-back FIFO with youngest-match lookup.
// Ports: push/pop, head entry, count/full/empty, lk_addr -> lk_hit/lk_data.
module wb_buffer #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [AW-1:0] pop_addr,
  output logic [DW-1:0] pop_data,
  input  logic [AW-1:0] lk_addr,
  output logic          lk_hit,
  output logic [DW-1:0] lk_data,
  output logic [1:0]    count,
  output logic          full,
  output logic          empty
);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  ent_t ent [2];
  ent_t nw;

  assign nw = {push_addr, push_data};

  // ent[0] is always the oldest entry
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count  <= 2'd0;
      ent[0] <= '0;
      ent[1] <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          ent[count[0]] <= nw;
          count         <= count + 2'd1;
        end
        2'b01: begin
          ent[0] <= ent[1];
          count  <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd2) begin
            ent[0] <= ent[1];
            ent[1] <= nw;
          end else begin
            ent[0] <= nw;
          end
        end
        default: ;
      endcase
    end
  end

  assign pop_addr = ent[0].addr;
  assign pop_data = ent[0].data;
  assign full     = (count == 2'd2);
  assign empty    = (count == 2'd0);

  // younger slot checked first so the newest write wins
  always_comb begin
    lk_hit  = 1'b0;
    lk_data = '0;
    unique case (1'b1)
      (count == 2'd2 && ent[1].addr == lk_addr): begin
        lk_hit  = 1'b1;
        lk_data = ent[1].data;
      end
      (count != 2'd0 && ent[0].addr == lk_addr): begin
        lk_hit  = 1'b1;
        lk_data = ent[0].data;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: backing store for line-fill reads and posted write-backs.
// Ports: req_* valid/ready request channel, resp_* valid/ready response channel.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DEPTH   = 4,
  parameter int LATENCY = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t            state, state_n;
  logic [3:0]        cnt, cnt_n;
  logic [DATA_W-1:0] rdata_q, rd_val;
  logic              err_q;

  // not reset: contents survive reset
  logic [DATA_W-1:0] mem [DEPTH];

  logic              in_range;
  logic              acc, rd_acc, wr_acc;
  logic              wb_pop, wb_full, wb_empty, wb_hit;
  logic [1:0]        wb_count;
  logic [ADDR_W-1:0] pop_addr;
  logic [DATA_W-1:0] pop_data, hit_data;
  logic              unused_ok;

  assign in_range  = 32'(req_addr) < 32'(DEPTH);
  assign req_ready = !reset && state == IDLE && !wb_full;
  assign acc       = req_valid && req_ready;
  assign rd_acc    = acc && !req_write;
  assign wr_acc    = acc && req_write && in_range;
  assign wb_pop    = !wb_empty;

  wb_buffer #(
    .AW(ADDR_W),
    .DW(DATA_W)
  ) u_wb (
    .clock    (clock),
    .reset    (reset),
    .push     (wr_acc),
    .push_addr(req_addr),
    .push_data(req_wdata),
    .pop      (wb_pop),
    .pop_addr (pop_addr),
    .pop_data (pop_data),
    .lk_addr  (req_addr),
    .lk_hit   (wb_hit),
    .lk_data  (hit_data),
    .count    (wb_count),
    .full     (wb_full),
    .empty    (wb_empty)
  );

  // pop takes effect after the edge, so a same-edge read still hits
  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      !in_range: rd_val = '0;
      wb_hit:    rd_val = hit_data;
      default:   rd_val = mem[req_addr[IW-1:0]];
    endcase
  end

  always_ff @(posedge clock) begin
    if (wb_pop)
      mem[pop_addr[IW-1:0]] <= pop_data;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (rd_acc) begin
          cnt_n   = LAT_M1;
          state_n = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1)
          state_n = RESP;
      end
      RESP: begin
        if (resp_ready)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (rd_acc) begin
        rdata_q <= rd_val;
        err_q   <= !in_range;
      end
    end
  end

  assign resp_valid = (state == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  assign unused_ok = ^{pop_addr[ADDR_W-1:IW], wb_count};

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed plus random checks of mem_responder
// against a transaction-level model of the store and its buffer.
module tb_mem_responder;

  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int LAT   = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;

  always #5 clock = ~clock;

  mem_responder #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .DEPTH  (DEPTH),
    .LATENCY(LAT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          a;
    logic [7:0]  d;
  } w_t;

  logic [7:0] back [DEPTH];
  w_t         pend [$];
  bit         busy = 0;
  bit         resp_on = 0;
  int         lat_left = 0;
  logic [7:0] exp_d = '0;
  logic       exp_e = 1'b0;

  function automatic void chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endfunction

  function automatic bit pred_ready();
    return !reset && !busy;
  endfunction

  // logical memory contents: drained store overlaid by buffered writes
  function automatic logic [7:0] view(int a);
    logic [7:0] v;
    v = back[a];
    foreach (pend[i])
      if (pend[i].a == a) v = pend[i].d;
    return v;
  endfunction

  function automatic void model_reset();
    pend.delete();
    busy     = 0;
    resp_on  = 0;
    lat_left = 0;
  endfunction

  task automatic check_outputs();
    chk("req_ready", req_ready, pred_ready());
    chk("resp_valid", resp_valid, resp_on);
    if (resp_on) begin
      chk("resp_rdata", resp_rdata, exp_d);
      chk("resp_err", resp_err, exp_e);
    end
  endtask

  task automatic tick();
    bit rdy;
    w_t w;
    rdy = pred_ready();
    @(posedge clock);
    if (!reset) begin
      if (resp_on && resp_ready) begin
        busy    = 0;
        resp_on = 0;
      end else if (busy && !resp_on) begin
        lat_left--;
        resp_on = (lat_left == 0);
      end
      if (req_valid && rdy && !req_write) begin
        busy     = 1;
        exp_e    = (req_addr >= DEPTH);
        exp_d    = exp_e ? 8'h00 : view(int'(req_addr));
        lat_left = LAT - 1;
        resp_on  = (lat_left == 0);
      end
      if (pend.size() > 0) begin
        w = pend.pop_front();
        back[w.a] = w.d;
      end
      if (req_valid && rdy && req_write && req_addr < DEPTH) begin
        w.a = int'(req_addr);
        w.d = req_wdata;
        pend.push_back(w);
      end
    end
    @(negedge clock);
    check_outputs();
  endtask

  task automatic do_reset(int cyc);
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_wb_count", dut.wb_count, 0);
    repeat (cyc) tick();
    reset = 1'b0;
    #1;
    chk("post_rst_ready", req_ready, 1);
  endtask

  task automatic issue(bit w, int a, int d);
    int n;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = 8'(a);
    req_wdata = 8'(d);
    n = 0;
    while (!pred_ready() && n < 100) begin
      tick();
      n++;
    end
    chk("issue_timeout", n < 100, 1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(bit rnd);
    int n;
    n = 0;
    while (busy && n < 200) begin
      if (rnd) resp_ready = 1'($urandom % 2);
      tick();
      n++;
    end
    chk("resp_timeout", busy, 0);
    resp_ready = 1'b1;
  endtask

  task automatic read_expect(string tag, int a, logic [7:0] d, logic e);
    int k;
    resp_ready = 1'b1;
    issue(0, a, 0);
    k = 0;
    while (!resp_valid && k < 50) begin
      tick();
      k++;
    end
    chk({tag, "_latency"}, k, LAT - 1);
    chk({tag, "_rdata"}, resp_rdata, d);
    chk({tag, "_err"}, resp_err, e);
    tick();
  endtask

  initial begin
    foreach (back[i]) back[i] = 8'h00;
    do_reset(2);

    // preload then read with fixed latency
    issue(1, 2, 8'h01);
    repeat (2) tick();
    read_expect("rd_a2", 2, 8'h01, 1'b0);

    // forwarding, then from the array
    issue(1, 1, 8'h03);
    read_expect("fwd_a1", 1, 8'h03, 1'b0);
    repeat (3) tick();
    read_expect("arr_a1", 1, 8'h03, 1'b0);

    // back-to-back writes, youngest wins
    issue(1, 0, 8'h05);
    issue(1, 0, 8'h07);
    read_expect("young_a0", 0, 8'h07, 1'b0);

    // out of range
    read_expect("oor_rd", 9, 8'h00, 1'b1);
    issue(1, 9, 8'hAA);
    chk("oor_wb_count", dut.wb_count, 0);
    read_expect("oor_rd2", 9, 8'h00, 1'b1);

    // backpressure
    resp_ready = 1'b0;
    issue(0, 2, 0);
    repeat (LAT - 1) tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", resp_valid, 1);
      chk("bp_rdata", resp_rdata, 8'h01);
      chk("bp_ready", req_ready, 0);
    end
    resp_ready = 1'b1;
    tick();
    chk("bp_release_ready", req_ready, 1);

    // reset drops an undrained write and a pending read
    issue(1, 3, 8'h55);
    do_reset(2);
    issue(0, 1, 0);
    tick();
    do_reset(1);
    repeat (5) tick();
    read_expect("post_rst_a3", 3, 8'h00, 1'b0);
    read_expect("post_rst_a1", 1, 8'h03, 1'b0);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      int r;
      r = int'($urandom % 16);
      if (r < 2) begin
        tick();
      end else if (r < 8) begin
        issue(1, int'($urandom % 8), int'($urandom % 256));
      end else begin
        issue(0, int'($urandom % 8), 0);
        if ($urandom % 40 == 0) begin
          tick();
          do_reset(1);
        end
        wait_resp(1'b1);
      end
    end
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
